// File: rtl/poly_eval_pkg.sv
// Shared types for poly_eval: FSM state encoding and legal parameter limits.
// No timing of its own; no flow control.
package poly_eval_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_LOAD      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_CALC      = 3'd2,
    S_DONE      = 3'd3,
    S_DONE_WAIT = 3'd4
  } state_e;

  localparam state_e STATE_RESET = S_LOAD;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 32;
  localparam int DEGREE_MIN = 1;
  localparam int DEGREE_MAX = 15;

  function automatic bit params_legal(input int width, input int degree);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (degree >= DEGREE_MIN) && (degree <= DEGREE_MAX);
  endfunction

endpackage

// File: rtl/poly_eval_mac.sv
// One Horner step acc*x + coef, modulo 2^WIDTH; wide overflow detect only with POLY_EVAL_OVF_EN.
// Purely combinational, no flow control.
module poly_mac #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] coef_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

`ifdef POLY_EVAL_OVF_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  assign prod  = {{WIDTH{1'b0}}, acc_i} * {{WIDTH{1'b0}}, x_i};
  assign sum   = {1'b0, prod[WIDTH-1:0]} + {1'b0, coef_i};
  assign res_o = sum[WIDTH-1:0];
  // A wrapped product or a carry out of the add both lose information.
  assign ovf_o = (|prod[2*WIDTH-1:WIDTH]) | sum[WIDTH];
`else
  logic [WIDTH-1:0] prod;

  assign prod  = acc_i * x_i;
  assign res_o = prod + coef_i;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/poly_eval.sv
// Horner polynomial evaluator with Go-handshaked operand load; optional overflow flag via POLY_EVAL_OVF_EN.
// Result DEGREE+1 edges after final Go release; each Go pulse moves one step, Go ignored while Busy.
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Go,
  input  logic [WIDTH-1:0]            DataIn,
  output logic [$clog2(DEGREE+2)-1:0] LoadIndex,
  output logic                        Busy,
  output logic [WIDTH-1:0]            DataResult,
  output logic                        ResultValid,
  output logic                        Overflow
);

  localparam int IDX_W     = $clog2(DEGREE + 2);
  localparam int LAST_SLOT = DEGREE + 1;

  if (!params_legal(WIDTH, DEGREE)) begin : g_bad_params
    $error("poly_eval: WIDTH=%0d DEGREE=%0d out of range", WIDTH, DEGREE);
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  // Slot 0 holds a_N, slot DEGREE holds a_0, slot DEGREE+1 holds x.
  logic [WIDTH-1:0] opnd_q [0:LAST_SLOT];
  logic [WIDTH-1:0] opnd_d [0:LAST_SLOT];
  logic [WIDTH-1:0] mac_res;
  logic             mac_ovf;
  logic             calc_start;

  poly_mac #(.WIDTH(WIDTH)) u_mac (
    .acc_i  (acc_q),
    .x_i    (opnd_q[LAST_SLOT]),
    .coef_i (opnd_q[k_q]),
    .res_o  (mac_res),
    .ovf_o  (mac_ovf)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    acc_d       = acc_q;
    res_d       = res_q;
    opnd_d      = opnd_q;
    calc_start  = 1'b0;
    Busy        = (state_q == S_CALC);
    ResultValid = (state_q == S_DONE);
    case (state_q)
      S_LOAD: begin
        if (Go) begin
          opnd_d[idx_q] = DataIn;
          state_d       = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (!Go) begin
          if (idx_q == IDX_W'(LAST_SLOT)) begin
            acc_d      = opnd_q[0];
            k_d        = IDX_W'(1);
            calc_start = 1'b1;
            state_d    = S_CALC;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_CALC: begin
        acc_d = mac_res;
        if (k_q == IDX_W'(DEGREE)) begin
          res_d   = mac_res;
          state_d = S_DONE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (Go) begin
          state_d = S_DONE_WAIT;
        end
      end
      S_DONE_WAIT: begin
        if (!Go) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q  <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      opnd_q <= '{default: '0};
    end else begin
      idx_q  <= idx_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      opnd_q <= opnd_d;
    end
  end

  assign LoadIndex  = idx_q;
  assign DataResult = res_q;

`ifdef POLY_EVAL_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky across the whole evaluation; only a new S_CALC entry clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (calc_start) begin
      ovf_d = 1'b0;
    end else if ((state_q == S_CALC) && mac_ovf) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = mac_ovf;
`endif

endmodule

// File: doc/poly_eval.md
POLY_EVAL -- requirements
Module: poly_eval

Interface
REQ-001 SHALL have parameter WIDTH, default 8; data and arithmetic width in bits, legal range 2..32.
REQ-002 SHALL have parameter DEGREE, default 2; polynomial degree N, legal range 1..15; evaluates a_N*x^N + ... + a_1*x + a_0.
REQ-003 SHALL have port Clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Go  in  1  level-sensitive load/advance request, sampled each Clock edge.
REQ-006 SHALL have port DataIn  in  WIDTH  coefficient or x value.
REQ-007 SHALL have port LoadIndex  out  $clog2(DEGREE+2)  next operand slot: 0 = a_N ... DEGREE = a_0, DEGREE+1 = x.
REQ-008 SHALL have port Busy  out  1  high only in S_CALC.
REQ-009 SHALL have port DataResult  out  WIDTH  registered polynomial result.
REQ-010 SHALL have port ResultValid  out  1  high only in S_DONE.
REQ-011 SHALL have port Overflow  out  1  sticky overflow flag for the last evaluation (see Configuration).

Function
REQ-012 SHALL implement states S_LOAD, S_LOAD_WAIT, S_CALC, S_DONE, S_DONE_WAIT.
REQ-013 S_LOAD, Go=1: SHALL capture DataIn into slot LoadIndex and go to S_LOAD_WAIT.
REQ-014 S_LOAD, Go=0: SHALL hold.
REQ-015 S_LOAD_WAIT, Go=1: SHALL hold with no further capture, so one Go pulse of any length loads exactly one operand.
REQ-016 S_LOAD_WAIT, Go=0, slot < DEGREE+1: SHALL increment LoadIndex and return to S_LOAD.
REQ-017 S_LOAD_WAIT, Go=0, slot = DEGREE+1: SHALL go to S_CALC, load accumulator with a_N, set step k=1, and clear Overflow.
REQ-018 S_CALC: SHALL compute exactly one Horner step per cycle, acc <= acc*x + a_(N-k), k++; Go SHALL be ignored.
REQ-019 S_CALC: after DEGREE cycles, SHALL write the final step's value into DataResult and enter S_DONE.
REQ-020 Latency SHALL be DEGREE+1 rising edges from the edge that sampled the final Go=0 to the first cycle with ResultValid=1.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH; products and sums truncated to WIDTH bits at every step.
REQ-022 S_DONE: SHALL hold ResultValid=1 and DataResult stable.
REQ-023 S_DONE, Go=1: SHALL go to S_DONE_WAIT.
REQ-024 S_DONE_WAIT: SHALL hold ResultValid=0; on Go=0 SHALL set LoadIndex=0 and enter S_LOAD.
REQ-025 DataResult SHALL retain the previous result until the next S_CALC completes; it SHALL NOT show intermediate accumulator values.
REQ-026 Operand registers SHALL retain contents until overwritten; a slot not yet reloaded keeps its old value.

Reset
REQ-027 On Reset=1 at a Clock edge, from any state including mid-S_CALC, SHALL enter S_LOAD.
REQ-028 On Reset=1 at a Clock edge SHALL set LoadIndex=0, Busy=0, ResultValid=0, DataResult=0, Overflow=0, and clear all operand registers and the accumulator.
REQ-029 Reset SHALL take priority over Go on the same edge.

Configuration
REQ-030 With macro POLY_EVAL_OVF_EN defined, Overflow SHALL set in any S_CALC cycle whose untruncated acc*x or sum exceeds 2^WIDTH-1, and SHALL stay set through S_DONE.
REQ-031 Without POLY_EVAL_OVF_EN, the Overflow port SHALL exist but be tied to 0, and the overflow detection logic SHALL NOT be synthesised.

Structure
REQ-032 Package poly_eval_pkg SHALL hold the state encoding type and state localparams; WIDTH and DEGREE limits SHALL be checked at elaboration.
REQ-033 The Horner step SHALL be sub-module poly_mac (acc, x, coef -> WIDTH-bit result, plus overflow output), instantiated once.

Verification
REQ-034 Default params, load 3,2,1 then x=4 -> DataResult=57 (0x39), ResultValid high exactly 3 edges after final Go release, Overflow=0.
REQ-035 OVF_EN, load 16,0,0 then x=4 -> DataResult=0x00, Overflow=1; without the macro, Overflow=0.
REQ-036 Hold Go high 20 cycles on the first load -> only slot 0 written, LoadIndex=1 after release.
REQ-037 Assert Reset during the second S_CALC cycle -> next cycle in S_LOAD, DataResult=0, ResultValid=0, LoadIndex=0.
REQ-038 WIDTH=16, DEGREE=3, load 1,0,0,5 then x=10 -> DataResult=1005, Busy high exactly 3 cycles.
REQ-039 In S_DONE pulse Go, then reload 0,0,7 and x=9 -> ResultValid drops while Go is high; DataResult keeps 57 until new result 7.
